// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the keyboard lines, frames
// 11-bit serial words and decodes make/break/extended scan-code events.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       KEY_VALID,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXTENDED,
  output logic       KEY_RELEASED,
  output logic       FRAME_ERROR
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift_reg, shift_n;
  logic          par_bit, par_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic          pend_ext, pend_ext_n, pend_rel, pend_rel_n;
  logic          valid_n, err_n, ext_n, rel_n;
  logic [7:0]    code_n;

  // Line conditioning: the filtered clock only follows the synchronized clock
  // once it has held its new level for FILTER_LEN consecutive samples.
  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= PS2_CLK;
      clk_s2    <= clk_s1;
      dat_s1    <= PS2_DATA;
      dat_s2    <= dat_s1;
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  always_ff @(posedge CLK_25MHZ or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_bit      <= 1'b0;
      tmo_cnt      <= '0;
      pend_ext     <= 1'b0;
      pend_rel     <= 1'b0;
      KEY_VALID    <= 1'b0;
      KEY_CODE     <= '0;
      KEY_EXTENDED <= 1'b0;
      KEY_RELEASED <= 1'b0;
      FRAME_ERROR  <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      shift_reg    <= shift_n;
      par_bit      <= par_n;
      tmo_cnt      <= tmo_n;
      pend_ext     <= pend_ext_n;
      pend_rel     <= pend_rel_n;
      KEY_VALID    <= valid_n;
      KEY_CODE     <= code_n;
      KEY_EXTENDED <= ext_n;
      KEY_RELEASED <= rel_n;
      FRAME_ERROR  <= err_n;
    end
  end

  // Frame sequencing and prefix decoding; event outputs register one cycle
  // after the stop-bit sample.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_reg;
    par_n      = par_bit;
    tmo_n      = (state == IDLE) ? '0 : tmo_cnt + TW'(1);
    pend_ext_n = pend_ext;
    pend_rel_n = pend_rel;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    code_n     = KEY_CODE;
    ext_n      = KEY_EXTENDED;
    rel_n      = KEY_RELEASED;

    if (fall) begin
      tmo_n = '0;
    end

    case (state)
      IDLE: begin
        if (fall && !dat_s2) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          shift_n   = {dat_s2, shift_reg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = dat_s2;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (dat_s2 && ((^shift_reg) ^ par_bit)) begin
            if (shift_reg == 8'hE0) begin
              pend_ext_n = 1'b1;
            end else if (shift_reg == 8'hF0) begin
              pend_rel_n = 1'b1;
            end else begin
              valid_n    = 1'b1;
              code_n     = shift_reg;
              ext_n      = pend_ext;
              rel_n      = pend_rel;
              pend_ext_n = 1'b0;
              pend_rel_n = 1'b0;
            end
          end else begin
            err_n      = 1'b1;
            pend_ext_n = 1'b0;
            pend_rel_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A stalled keyboard clock abandons the partial frame.
    if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n    = IDLE;
      tmo_n      = '0;
      err_n      = 1'b1;
      pend_ext_n = 1'b0;
      pend_rel_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: vector table, hand-built corner
// sequences and a randomized run against a prefix-decoding reference model.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       frame_error;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int err_cycle = 0;
  int last_fall = 0;
  logic overlap = 1'b0;

  logic       m_ext, m_rel;
  logic [7:0] m_code;
  logic       m_oext, m_orel;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_code;
    logic       exp_ext;
    logic       exp_rel;
  } vec_t;

  vec_t vecs[12];

  ps2_keyboard_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLK_25MHZ   (clk),
    .RESET       (rst),
    .PS2_CLK     (ps2_clk),
    .PS2_DATA    (ps2_data),
    .KEY_VALID   (key_valid),
    .KEY_CODE    (key_code),
    .KEY_EXTENDED(key_extended),
    .KEY_RELEASED(key_released),
    .FRAME_ERROR (frame_error)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (key_valid) valid_cnt <= valid_cnt + 1;
    if (frame_error) begin
      err_cnt   <= err_cnt + 1;
      err_cycle <= cycle;
    end
    if (key_valid && frame_error) overlap <= 1'b1;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic bad_par, input logic bad_stop,
                                input int nbits, input logic glitch);
    logic [10:0] f;
    f = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      if (glitch) begin
        wait_cycles(10);
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(HALF - 13);
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk   = 1'b0;
      last_fall = cycle;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    wait_cycles(2 * HALF);
    ps2_data = 1'b1;
  endtask

  task automatic frame_check(input string name, input logic [7:0] data, input logic bad_par,
                             input logic bad_stop, input logic glitch, input int exp_v,
                             input int exp_e, input logic [7:0] exp_code, input logic exp_ext,
                             input logic exp_rel);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    apply_stimulus(data, bad_par, bad_stop, 11, glitch);
    check_output({name, ".valid_pulses"}, valid_cnt - v0, exp_v);
    check_output({name, ".error_pulses"}, err_cnt - e0, exp_e);
    check_output({name, ".code"}, key_code, exp_code);
    check_output({name, ".extended"}, key_extended, exp_ext);
    check_output({name, ".released"}, key_released, exp_rel);
  endtask

  // Reference model: prefix bytes arm flags, errors drop them, anything else is an event.
  task automatic model_frame(input logic [7:0] data, input logic bad, output int ev, output int er);
    ev = 0;
    er = 0;
    if (bad) begin
      er = 1;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (data == 8'hE0) begin
      m_ext = 1'b1;
    end else if (data == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      ev     = 1;
      m_code = data;
      m_oext = m_ext;
      m_orel = m_rel;
      m_ext  = 1'b0;
      m_rel  = 1'b0;
    end
  endtask

  initial begin
    int v0, e0, lat, ev, er;
    logic [7:0] d;
    logic bad;

    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[3]  = '{8'h75, 1'b0, 1'b0, 1, 0, 8'h75, 1'b1, 1'b1};
    vecs[4]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[5]  = '{8'h1C, 1'b1, 1'b0, 0, 1, 8'h1C, 1'b0, 1'b0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[7]  = '{8'h33, 1'b0, 1'b1, 0, 1, 8'h1C, 1'b0, 1'b0};
    vecs[8]  = '{8'h6B, 1'b0, 1'b0, 1, 0, 8'h6B, 1'b0, 1'b0};
    vecs[9]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h6B, 1'b0, 1'b0};
    vecs[10] = '{8'h6B, 1'b1, 1'b0, 0, 1, 8'h6B, 1'b0, 1'b0};
    vecs[11] = '{8'h74, 1'b0, 1'b0, 1, 0, 8'h74, 1'b0, 1'b0};

    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);
    check_output("reset.valid", key_valid, 0);
    check_output("reset.code", key_code, 0);
    check_output("reset.extended", key_extended, 0);
    check_output("reset.released", key_released, 0);
    check_output("reset.error", frame_error, 0);
    rst = 1'b0;
    wait_cycles(10);

    for (int i = 0; i < 12; i++) begin
      frame_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 1'b0,
                  vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_ext,
                  vecs[i].exp_rel);
    end

    frame_check("glitch", 8'h1C, 1'b0, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0);

    v0 = valid_cnt;
    e0 = err_cnt;
    apply_stimulus(8'h0F, 1'b0, 1'b0, 5, 1'b0);
    wait_cycles(2 * TIMEOUT);
    lat = err_cycle - last_fall;
    check_output("timeout.error_pulses", err_cnt - e0, 1);
    check_output("timeout.valid_pulses", valid_cnt - v0, 0);
    check_output("timeout.latency_in_window", (lat >= TIMEOUT && lat <= TIMEOUT + FILTER_LEN + 8), 1);
    check_output("timeout.code_kept", key_code, 8'h1C);
    frame_check("after_timeout", 8'h29, 1'b0, 1'b0, 1'b0, 1, 0, 8'h29, 1'b0, 1'b0);

    frame_check("pre_reset_prefix", 8'hE0, 1'b0, 1'b0, 1'b0, 0, 0, 8'h29, 1'b0, 1'b0);
    apply_stimulus(8'h5A, 1'b0, 1'b0, 6, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(3);
    check_output("midreset.valid", key_valid, 0);
    check_output("midreset.code", key_code, 0);
    check_output("midreset.extended", key_extended, 0);
    check_output("midreset.released", key_released, 0);
    check_output("midreset.error", frame_error, 0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(20);
    frame_check("after_reset", 8'h5A, 1'b0, 1'b0, 1'b0, 1, 0, 8'h5A, 1'b0, 1'b0);

    m_ext  = 1'b0;
    m_rel  = 1'b0;
    m_code = 8'h5A;
    m_oext = 1'b0;
    m_orel = 1'b0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0:       begin d = 8'hE0; bad = 1'b0; end
        1:       begin d = 8'hF0; bad = 1'b0; end
        2:       begin d = 8'($urandom); bad = 1'b1; end
        default: begin d = 8'($urandom); bad = 1'b0; end
      endcase
      model_frame(d, bad, ev, er);
      frame_check($sformatf("rand%0d", i), d, bad, 1'b0, 1'b0, ev, er, m_code, m_oext, m_orel);
    end

    check_output("no_valid_error_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
